// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter feeding a serial-load shift register.
// Accepts one W-bit word on DIN_VALID/DIN_READY and shifts it out one bit per clock,
// MSB-first (RL=0) or LSB-first (RL=1). If enabled, an even-parity bit follows the data.
// A one-cycle DONE strobe marks the end of each word.
//
// Ports:
//   CLK, RST             clock (rising edge); synchronous active-low reset
//   DIN, DIN_VALID       parallel word and its valid flag
//   DIN_READY            word accepted on this edge if DIN_VALID=1 (combinational)
//   RL                   bit order, sampled when a word is accepted
//   SOUT, FRAME          serial bit; FRAME=1 while SOUT carries a data bit (registered)
//   PAR_STB, DONE        parity-bit marker and end-of-word strobe (registered)
module serial_tx #(
  parameter int W      = 8,
  parameter int PAR_EN = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] DIN,
  input  logic         DIN_VALID,
  output logic         DIN_READY,
  input  logic         RL,
  output logic         SOUT,
  output logic         FRAME,
  output logic         PAR_STB,
  output logic         DONE
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   sh_q;      // shift register, drained toward the output end
  logic [W-1:0]   word_q;    // untouched copy of the accepted word, used for parity
  logic [CW-1:0]  cnt_q;     // index of the bit currently on SOUT
  logic           rl_q;
  logic           sout_q;
  logic           frame_q;
  logic           par_stb_q;
  logic           done_q;

  logic [W-1:0]   sh_d;
  logic           last_bit;

  // Register contents after one more shift; the bit that will be on SOUT next
  // sits at the output end of sh_d.
  always_comb begin
    sh_d     = rl_q ? (sh_q >> 1) : (sh_q << 1);
    last_bit = (cnt_q == LAST);
  end

  assign DIN_READY = (state_q == S_IDLE) && RST;

  assign SOUT    = sout_q;
  assign FRAME   = frame_q;
  assign PAR_STB = par_stb_q;
  assign DONE    = done_q;

  // Outputs are registered: every branch computes the value SOUT/FRAME/PAR_STB/DONE
  // must show in the cycle that follows this edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      rl_q      <= 1'b0;
      sout_q    <= 1'b0;
      frame_q   <= 1'b0;
      par_stb_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (DIN_VALID) begin
            state_q <= S_SHIFT;
            sh_q    <= DIN;
            word_q  <= DIN;
            rl_q    <= RL;
            cnt_q   <= '0;
            sout_q  <= RL ? DIN[0] : DIN[W-1];
            frame_q <= 1'b1;
          end
        end

        S_SHIFT: begin
          sh_q <= sh_d;
          if (last_bit) begin
            frame_q <= 1'b0;
            if (PAR_EN != 0) begin
              state_q   <= S_PARITY;
              par_stb_q <= 1'b1;
              sout_q    <= ^word_q;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              sout_q  <= 1'b0;
            end
          end else begin
            // Hold the counter at W-1 on the last bit so it never wraps mid-word.
            cnt_q  <= cnt_q + CW'(1);
            sout_q <= rl_q ? sh_d[0] : sh_d[W-1];
          end
        end

        S_PARITY: begin
          state_q   <= S_DONE;
          par_stb_q <= 1'b0;
          done_q    <= 1'b1;
          sout_q    <= 1'b0;
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (W=8 with parity, W=4 without parity).
// A queue-based transaction model predicts every output cycle by cycle, and directed
// sequences pin the model with hand-derived literal bit patterns.
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din_a;
  logic       vld_a, rl_a;
  logic       rdy_a, sout_a, frame_a, par_a, done_a;
  logic [3:0] din_b;
  logic       vld_b, rl_b;
  logic       rdy_b, sout_b, frame_b, par_b, done_b;

  serial_tx #(.W(8), .PAR_EN(1)) u_a (
    .CLK(clk), .RST(rst), .DIN(din_a), .DIN_VALID(vld_a), .DIN_READY(rdy_a),
    .RL(rl_a), .SOUT(sout_a), .FRAME(frame_a), .PAR_STB(par_a), .DONE(done_a)
  );

  serial_tx #(.W(4), .PAR_EN(0)) u_b (
    .CLK(clk), .RST(rst), .DIN(din_b), .DIN_VALID(vld_b), .DIN_READY(rdy_b),
    .RL(rl_b), .SOUT(sout_b), .FRAME(frame_b), .PAR_STB(par_b), .DONE(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: each queue holds the remaining busy cycles of the word in
  // flight as {sout, frame, par_stb, done}. An empty queue means idle (ready).
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  always @(posedge clk) begin
    if (!rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() != 0) void'(qa.pop_front());
      else if (vld_a) begin
        for (int i = 0; i < 8; i++) qa.push_back({(rl_a ? din_a[i] : din_a[7-i]), 3'b100});
        qa.push_back({^din_a, 3'b010});
        qa.push_back(4'b0001);
      end
      if (qb.size() != 0) void'(qb.pop_front());
      else if (vld_b) begin
        for (int i = 0; i < 4; i++) qb.push_back({(rl_b ? din_b[i] : din_b[3-i]), 3'b100});
        qb.push_back(4'b0001);
      end
    end
  end

  // Loopback receiver: a W=8 serial-load shift register shifting every cycle.
  logic [7:0] lb;
  logic       lb_rl;
  always @(posedge clk) lb <= lb_rl ? {sout_a, lb[7:1]} : {lb[6:0], sout_a};

  // Single compare process, mid-cycle on the falling edge.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    logic [4:0] ea, eb;
    if (chk_en) begin
      ea = {((qa.size() != 0) ? qa[0] : 4'b0000), ((qa.size() == 0) && rst)};
      eb = {((qb.size() != 0) ? qb[0] : 4'b0000), ((qb.size() == 0) && rst)};
      chk("cyc_a{sout,frame,par,done,rdy}", {27'b0, sout_a, frame_a, par_a, done_a, rdy_a}, {27'b0, ea});
      chk("cyc_b{sout,frame,par,done,rdy}", {27'b0, sout_b, frame_b, par_b, done_b, rdy_b}, {27'b0, eb});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Send one word on instance A and check the literal bit sequence (seq[7] is the
  // first cycle), the parity bit, the loopback register, DONE and the return to idle.
  task automatic a_word(input logic [7:0] d, input logic r, input logic [7:0] seq,
                        input logic par, input string nm);
    din_a = d; rl_a = r; vld_a = 1'b1; lb_rl = r;
    tick;
    vld_a = 1'b0; din_a = 8'($urandom); rl_a = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      chk({nm, "_bit"}, sout_a, seq[7-i]);
      chk({nm, "_frame"}, frame_a, 1'b1);
      tick;
    end
    chk({nm, "_par"}, {sout_a, par_a, frame_a}, {par, 2'b10});
    chk({nm, "_loopback"}, lb, d);
    tick;
    chk({nm, "_done"}, {done_a, rdy_a}, 2'b10);
    tick;
    chk({nm, "_idle"}, {done_a, rdy_a}, 2'b01);
  endtask

  initial begin
    int acc_cyc[$];
    rst = 1'b0; din_a = '0; vld_a = 1'b0; rl_a = 1'b0; lb_rl = 1'b0;
    din_b = '0; vld_b = 1'b0; rl_b = 1'b0;

    // Reset state
    tick;
    chk_en = 1'b1;
    tick;
    chk("rst_a_outs", {sout_a, frame_a, par_a, done_a, rdy_a}, 5'b0);
    chk("rst_b_outs", {sout_b, frame_b, par_b, done_b, rdy_b}, 5'b0);
    rst = 1'b1;
    #1;
    chk("rst_release_rdy", {rdy_a, rdy_b}, 2'b11);
    tick;

    // MSB-first 0xA5, LSB-first 0x1E, MSB-first 0x07, then loopback words
    a_word(8'hA5, 1'b0, 8'b10100101, 1'b0, "t1_a5");
    a_word(8'h1E, 1'b1, 8'b01111000, 1'b0, "t2_1e");
    a_word(8'h07, 1'b0, 8'b00000111, 1'b1, "t2_07");
    a_word(8'h3C, 1'b0, 8'b00111100, 1'b0, "t3_3c");
    a_word(8'hC1, 1'b1, 8'b10000011, 1'b1, "t3_c1");

    // Valid held high with DIN changing every cycle: accepts exactly W+3 apart
    vld_a = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (rdy_a) acc_cyc.push_back(c);
      din_a = 8'($urandom); rl_a = 1'($urandom);
      tick;
    end
    vld_a = 1'b0;
    chk("b2b_count", acc_cyc.size(), 5);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 11);
    repeat (12) tick;

    // Reset asserted in cycle 4 of a word aborts it without DONE
    din_a = 8'h5A; rl_a = 1'b0; vld_a = 1'b1;
    tick;
    vld_a = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("t5_abort", {sout_a, frame_a, par_a, done_a, rdy_a}, 5'b0);
    tick;
    chk("t5_hold", {sout_a, frame_a, done_a, rdy_a}, 4'b0);
    rst = 1'b1;
    #1;
    chk("t5_rdy_after", rdy_a, 1'b1);
    tick;
    a_word(8'hFF, 1'b0, 8'hFF, 1'b0, "t5_ff");

    // W=4 without parity: 0x9 MSB-first
    din_b = 4'h9; rl_b = 1'b0; vld_b = 1'b1;
    tick;
    vld_b = 1'b0; din_b = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("t6_bit", {sout_b, frame_b, par_b}, {((i == 0) || (i == 3)) ? 1'b1 : 1'b0, 2'b10});
      tick;
    end
    chk("t6_done", {done_b, par_b, frame_b, rdy_b}, 4'b1000);
    tick;
    chk("t6_idle", {done_b, rdy_b}, 2'b01);

    // Randomized traffic on both instances with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 99) != 0);
      vld_a = 1'($urandom); din_a = 8'($urandom); rl_a = 1'($urandom);
      vld_b = 1'($urandom); din_b = 4'($urandom); rl_b = 1'($urandom);
      tick;
    end
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0;
    repeat (20) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter. It is the sending end for the team's serial-load shift register, reg_sl, configured with PS=0.
- Accepts one W-bit word over a valid/ready handshake, shifts it out one bit per clock, MSB-first or LSB-first, with an optional even-parity bit.
- Signals end-of-word with a one-cycle DONE strobe.
- Sits between the datapath register file and any serial peripheral or loopback receiver.

Parameters:
W, 8, data word width; legal range 2..32.
PAR_EN, 0, 1 = append one even-parity bit after the data bits; 0 = no parity bit.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  reset, synchronous, active-low.
DIN  input  W  parallel word to transmit.
DIN_VALID  input  1  DIN holds a word to send.
DIN_READY  output  1  transmitter can accept a word this cycle.
RL  input  1  bit order, sampled at accept. 0 = MSB first, matching reg_sl RL=0 with SiR=SOUT. 1 = LSB first, matching reg_sl RL=1 with SiL=SOUT.
SOUT  output  1  serial data bit.
FRAME  output  1  high while SOUT carries a data bit.
PAR_STB  output  1  high while SOUT carries the parity bit.
DONE  output  1  one-cycle end-of-word strobe.

Behaviour:
- Reset:
  - Any rising CLK edge with RST=0 forces state IDLE, clears the shift register, clears the bit counter, and clears the latched RL.
  - SOUT=0, FRAME=0, PAR_STB=0, DONE=0.
  - DIN_READY = (state==IDLE) AND RST, so it is 0 while RST=0.
  - Reset mid-word aborts the word immediately; no DONE is generated.
- Output timing: SOUT, FRAME, PAR_STB and DONE are registered outputs. DIN_READY is combinational from state and RST.
- Accept: occurs at a rising edge with DIN_VALID=1, DIN_READY=1 and RST=1. The edge latches DIN into the shift register, latches RL, and clears the counter. DIN_VALID is ignored outside IDLE.
- States:
  - IDLE:
    - DIN_READY=1.
    - On accept, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT:
    - FRAME=1. SOUT = shift-register MSB if latched RL=0, LSB if latched RL=1.
    - Each edge shifts the register one place toward the output end and increments the counter.
    - After W cycles (counter reaches W-1 at the edge), go to PARITY if PAR_EN=1, else DONE.
  - PARITY:
    - One cycle. PAR_STB=1, FRAME=0.
    - SOUT = XOR-reduction of the accepted word (even parity: total ones including the parity bit is even).
    - Next state DONE.
  - DONE:
    - One cycle. DONE=1, SOUT=0, FRAME=0, DIN_READY=0.
    - Next state IDLE.
- Parity source: the XOR is computed from a copy of the word captured at accept, not from the shifting register.
- Latency, with accept at edge 0:
  - Data bits appear in cycles 1..W.
  - Parity bit in cycle W+1 (if PAR_EN=1).
  - DONE in cycle W+1 (PAR_EN=0) or W+2 (PAR_EN=1).
  - Next accept possible at the edge ending the first IDLE cycle. Minimum word period is W+3 cycles (PAR_EN=1) or W+2 cycles (PAR_EN=0).
- Counter: width clog2(W); it never wraps within a word.
- Input stability: changes to DIN or RL after accept do not affect the word in flight.
- Simultaneous events: RST=0 has priority over accept and over every state transition.
- Loopback contract: a reg_sl of width W, PS=0, with RL and the serial input set to match this block's RL and SOUT, holds the transmitted word in the first cycle after FRAME falls.

Test Plan:
1. W=8, PAR_EN=1, RL=0, DIN=0xA5 accepted at edge 0 -> SOUT=1,0,1,0,0,1,0,1 in cycles 1-8 with FRAME=1; cycle 9 SOUT=0, PAR_STB=1; cycle 10 DONE=1; DIN_READY=1 again in cycle 11.
2. W=8, PAR_EN=1, RL=1, DIN=0x1E -> SOUT=0,1,1,1,1,0,0,0 in cycles 1-8; parity 0. Then DIN=0x07 with RL=0 -> SOUT=0,0,0,0,0,1,1,1; parity bit 1.
3. Loopback: reg_sl W=8, PS=0, RL=0, SiR=SOUT; send 0x3C -> reg_sl output = 0x3C in the cycle after FRAME falls. Repeat with RL=1 into SiL using 0xC1 -> 0xC1.
4. DIN_VALID held 1 with DIN changing every cycle during SHIFT -> only the accepted word is transmitted; no second accept before IDLE. Back-to-back valid words are spaced exactly W+3 cycles apart (PAR_EN=1).
5. RST=0 asserted in cycle 4 of a word -> next edge gives SOUT=0, FRAME=0, DONE=0, DIN_READY=0 while RST=0. After release, DIN_READY=1 and a new word 0xFF transmits correctly with parity 0.
6. PAR_EN=0, W=4, DIN=0x9 -> SOUT=1,0,0,1 in cycles 1-4; PAR_STB never asserts; DONE in cycle 5.
